// File: rtl/entropy_collector_if.sv
// Register bus shared with the ring-oscillator entropy source: chip select,
// write enable, 8-bit address, 16-bit write data and combinational read data.
interface entropy_collector_if;
    logic        cs;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] dwrite;
    logic [15:0] dread;

    modport master (output cs, we, addr, dwrite, input dread);
    modport slave  (input cs, we, addr, dwrite, output dread);
endinterface

// File: rtl/entropy_collector.sv
// Entropy collector: synchronise oscillator outputs, sample them, pack the bits
// into 16-bit words and buffer four words. ENTROPY_COLLECTOR_VN_EN adds von Neumann debiasing.
module entropy_collector #(
    parameter logic [15:0] SAMPLE_DIV = 16'd64
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic [15:0]                p_in,
    input  logic [15:0]                n_in,
    entropy_collector_if.slave         bus,
    output logic                       word_avail,
    output logic [7:0]                 debug
);

    logic [15:0]       sync_q, raw_sync;
    logic              raw_bit, enable, tick;
    logic [15:0]       div_ctr;
    logic              rd_en, ctrl_wr, flush, disable_ev;
    logic              bit_vld, bit_val;
    logic [15:0]       shreg;
    logic [3:0]        bitcnt;
    logic              push, pop, wr_ok, full, empty;
    logic [15:0]       word;
    logic [3:0][15:0]  mem;
    logic [1:0]        wptr, rptr;
    logic [2:0]        cnt;
    logic [7:0]        ovf_cnt;
    logic              unused_wdata;

    assign unused_wdata = ^bus.dwrite[15:2];

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q   <= '0;
            raw_sync <= '0;
        end else begin
            sync_q   <= p_in ^ n_in;
            raw_sync <= sync_q;
        end
    end

    assign raw_bit    = ^raw_sync;
    assign rd_en      = bus.cs & ~bus.we;
    assign ctrl_wr    = bus.cs & bus.we & (bus.addr == 8'h00);
    assign flush      = ctrl_wr & bus.dwrite[1];
    assign disable_ev = ctrl_wr & enable & ~bus.dwrite[0];
    assign tick       = enable & (div_ctr == SAMPLE_DIV - 16'd1);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            enable  <= 1'b0;
            div_ctr <= '0;
        end else begin
            if (ctrl_wr)
                enable <= bus.dwrite[0];
            if (!enable || tick)
                div_ctr <= '0;
            else
                div_ctr <= div_ctr + 16'd1;
        end
    end

`ifdef ENTROPY_COLLECTOR_VN_EN
    logic pend_vld, pend_bit;

    // First sample of a pair is held; an unequal pair emits its first sample.
    assign bit_vld = tick & pend_vld & (pend_bit != raw_bit);
    assign bit_val = pend_bit;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pend_vld <= 1'b0;
            pend_bit <= 1'b0;
        end else if (flush || disable_ev) begin
            pend_vld <= 1'b0;
        end else if (tick) begin
            pend_vld <= ~pend_vld;
            if (!pend_vld)
                pend_bit <= raw_bit;
        end
    end
`else
    assign bit_vld = tick;
    assign bit_val = raw_bit;
`endif

    assign word = {shreg[14:0], bit_val};
    assign push = bit_vld & (bitcnt == 4'd15);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else if (flush) begin
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            if (bit_vld) begin
                shreg  <= word;
                bitcnt <= bitcnt + 4'd1;
            end
            if (disable_ev)
                bitcnt <= '0;
        end
    end

    assign full       = (cnt == 3'd4);
    assign empty      = (cnt == 3'd0);
    assign pop        = rd_en & (bus.addr == 8'h11) & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    assign wr_ok      = push & (~full | pop);
    assign word_avail = ~empty;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            mem     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            ovf_cnt <= '0;
            debug   <= '0;
        end else if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            ovf_cnt <= '0;
        end else begin
            if (wr_ok) begin
                mem[wptr] <= word;
                wptr      <= wptr + 2'd1;
                debug     <= word[7:0];
            end else if (push && ovf_cnt != 8'hFF) begin
                ovf_cnt <= ovf_cnt + 8'd1;
            end
            if (pop)
                rptr <= rptr + 2'd1;
            cnt <= cnt + {2'b0, wr_ok} - {2'b0, pop};
        end
    end

    always_comb begin
        bus.dread = '0;
        if (rd_en) begin
            case (bus.addr)
                8'h10:   bus.dread = {ovf_cnt, 3'b0, cnt, full, empty};
                8'h11:   bus.dread = empty ? 16'h0000 : mem[rptr];
                8'h12:   bus.dread = raw_sync;
                8'h13:   bus.dread = {15'b0, enable};
                default: bus.dread = '0;
            endcase
        end
    end

endmodule

// File: doc/entropy_collector.md
# entropy_collector

Downstream consumer of the ring-oscillator entropy source. Synchronises the 16 `p` and 16 `n` oscillator outputs and samples them at a programmable rate, reducing each sample to one raw bit. Optionally applies von Neumann debiasing, packs the bits into 16-bit words and buffers the words in a 4-entry FIFO. Host software reads the words through the same 16-bit `cs`/`we`/`addr` register bus used by the entropy source.

## Interface
- `SAMPLE_DIV`, default 16'd64: clk cycles between raw-bit samples; legal range 2..65535.
- `clk` input 1: clock.
- `nreset` input 1: reset, asynchronous, active-low.
- `p_in` input 16: `p` oscillator outputs; asynchronous to `clk`.
- `n_in` input 16: `n` oscillator outputs; asynchronous to `clk`.
- `cs` input 1: register chip select.
- `we` input 1: write enable; 0 = read.
- `addr` input 8: register address.
- `dwrite` input 16: write data.
- `dread` output 16: read data; combinational; 0x0000 unless `cs & ~we`.
- `word_avail` output 1: FIFO not empty.
- `debug` output 8: low byte of the last word pushed into the FIFO.

## Operation
- **Synchroniser.** `p_in ^ n_in` passes through a 2-flop synchroniser to give `raw_sync[15:0]`.
- **Raw bit.** `raw_bit = ^raw_sync`, the XOR-reduce of all 16 bits.
- **Sample divider.** `div_ctr` counts 0..SAMPLE_DIV-1 while `enable`=1 and wraps to 0. `tick` is asserted in the cycle where `div_ctr == SAMPLE_DIV-1`. While `enable`=0, `div_ctr` is held at 0.
- **Debiaser.** Present only with the macro; see Configuration. It consumes `raw_bit` on each `tick` and emits 0 or 1 output bits.
- **Packer.** Each output bit is shifted into `shreg` at the LSB (`shreg <= {shreg[14:0], bit}`), so the first bit ends at bit 15. A 4-bit `bitcnt` counts the bits. When the 16th bit arrives, `{shreg[14:0], bit}` is pushed to the FIFO and `bitcnt` returns to 0.
- **FIFO.** 4 x 16 bits, implemented as circular read/write pointers plus a count of 0..4.
  - Push while full (and no pop in the same cycle): the word is dropped and `ovf_cnt` increments, saturating at 0xFF.
  - Pop happens when `cs & ~we & addr==0x11` and the FIFO is not empty. The pop is one per asserted cycle.
  - Reading 0x11 while empty returns 0x0000 and has no effect.
  - Push and pop in the same cycle: both take effect, including when the FIFO is full. The count is unchanged.
- **Write registers** (`cs & we`):
  - 0x00 CTRL: bit0 = `enable`, stored. Bit1 = `flush`, self-clearing strobe that is not stored.
  - Other addresses: ignored.
- **Flush** clears the FIFO, `shreg`, `bitcnt`, the pending pair bit and `ovf_cnt`. A flush wins over a push or pop in the same cycle.
- **Disable.** A 1→0 transition on `enable` discards the partial word (clears `bitcnt` and the pending pair bit). FIFO contents are kept.
- **Read registers** (`cs & ~we`):
  - 0x10 STATUS: `{ovf_cnt[7:0], 3'b0, fill[2:0], full, empty}`.
  - 0x11 DATA: FIFO head word; the read pops the FIFO.
  - 0x12 RAW: `raw_sync`.
  - 0x13 CTRL: `{15'b0, enable}`.
  - Other addresses: 0x0000.
- **Reset values:**
  - `enable`=0, FIFO empty, `shreg`=0, `bitcnt`=0, `ovf_cnt`=0, synchroniser flops 0.
  - Outputs: `dread`=0x0000, `word_avail`=0, `debug`=0x00.

## Timing
- Raw input to `raw_sync`: 2 cycles.
- First `tick` comes SAMPLE_DIV cycles after the CTRL write that sets `enable`.
- Packer and FIFO push are registered on the `tick` edge. `word_avail` and STATUS reflect the new word in the cycle after the tick that completed it.
- DATA read: `dread` shows the head word combinationally during the read cycle. The pointer advances at the end of that cycle; the next word is visible in the following cycle.
- A CTRL write takes effect on the next clock edge.
- `nreset` asserted mid-operation immediately returns everything to the reset values; no partial words survive.

## Configuration
- **`ENTROPY_COLLECTOR_VN_EN` defined:** von Neumann debiasing is compiled in. `raw_bit` samples are taken in pairs (a, b), with a being the first sample.
  - 01 → output 0.
  - 10 → output 1.
  - 00 and 11 → discarded.
  - A 16-bit word therefore needs at least 32 ticks.
- **Macro undefined:** the debiaser and the pending-pair flop are absent, and each tick shifts `raw_bit` directly into the packer (16 ticks per word).

## Test plan
1. Reset, then read 0x10, 0x11, 0x13 → 0x0001, 0x0000, 0x0000; `word_avail`=0; `debug`=0x00.
2. SAMPLE_DIV=4, VN on. Drive `p_in`=0x0001, `n_in`=0x0000 constantly and write CTRL=0x0001. Run 200 cycles → no word and STATUS=0x0001.
3. SAMPLE_DIV=4, VN on. Toggle `p_in` between 0x0001 and 0x0000 so the raw bits are 1,0,1,0,... from the first tick. After 32 ticks, `word_avail`=1 and DATA=0xFFFF. Then STATUS=0x0001.
4. VN off. Constant raw bit 1 for 80 ticks → 5 words: 4 stored, 1 dropped. STATUS=0x0112. Four DATA reads return 0xFFFF each; the fifth read returns 0x0000.
5. FIFO full with a DATA read coinciding with a push → count stays 4 and `ovf_cnt` is unchanged. Write CTRL=0x0003 (flush) → STATUS=0x0001 and `enable` stays 1.
6. Clear `enable` after 8 of 16 bits, then set it again. The next word is built from 16 fresh bits only. Assert `nreset` mid-word → all registers return to their reset values.
